hilo_mul_ctrl: RTL
==================

Name: hilo_mul_ctrl

Overview:
- EX-stage controller that sits directly upstream of the 32x32 sequential multiplier and downstream of it for result writeback.
- Accepts MULT/MULTU, MTHI/MTLO from EX, drives the multiplier handshake, holds the pipeline via stallreq, and owns the architectural HI/LO registers that MFHI/MFLO read.

Parameters:
- DW, 32, operand width (HI/LO width; product is 2*DW).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- ex_mul_valid_i  in  1  EX holds a MULT/MULTU
- ex_mul_signed_i  in  1  1=MULT, 0=MULTU
- ex_rs_i  in  DW  multiplicand
- ex_rt_i  in  DW  multiplier
- ex_mthi_i  in  1  MTHI in EX
- ex_mtlo_i  in  1  MTLO in EX
- ex_wdata_i  in  DW  MTHI/MTLO data
- mul_start_o  out  1  multiplier start/hold (1=run/hold result, 0=stop)
- mul_signed_o  out  1  signed select to multiplier
- mul_a_o  out  DW  registered operand A
- mul_b_o  out  DW  registered operand B
- mul_result_i  in  2*DW  product {hi,lo}
- mul_ready_i  in  1  multiplier result valid
- hi_o  out  DW  HI register
- lo_o  out  DW  LO register
- stallreq_o  out  1  pipeline stall request (combinational)

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Reset values:
  - state=IDLE, mul_start_o=1, mul_signed_o=0, mul_a_o=0, mul_b_o=0, hi_o=0, lo_o=0.
  - mul_start_o=1 at reset so the multiplier parks in its result-hold state with mul_ready_i=1.
- States:
  - IDLE: mul_start_o=1.
    - If ex_mul_valid_i && mul_ready_i: latch ex_rs_i/ex_rt_i/ex_mul_signed_i into mul_a_o/mul_b_o/mul_signed_o, drive mul_start_o<=0, go to KICK.
    - If ex_mul_valid_i && !mul_ready_i (multiplier not yet parked, e.g. just after reset): stay in IDLE.
  - KICK: mul_start_o<=1, go to ARM. The multiplier returns to free at this edge and samples the held operands next cycle.
  - ARM: wait for mul_ready_i==0. Any stale ready seen here is ignored. On mul_ready_i==0, go to BUSY.
  - BUSY: wait for mul_ready_i==1. Then capture {hi_o,lo_o}<=mul_result_i and go to IDLE. mul_start_o stays 1, so the multiplier parks again.
- mul_a_o, mul_b_o and mul_signed_o remain stable from KICK through BUSY.
- stallreq_o:
  - High in IDLE when ex_mul_valid_i=1.
  - High in KICK and ARM.
  - High in BUSY while mul_ready_i=0.
  - Low in BUSY when mul_ready_i=1, so the instruction leaves EX on the same edge HI/LO are written.
  - Low otherwise.
- Latency: issue cycle to release is 38 cycles with the 32-iteration multiplier (IDLE, KICK, ARM, multiplier free, 33 run cycles, end, ready). No early-out.
- MTHI/MTLO:
  - Write hi_o/lo_o at the clock edge, in IDLE only, with no stall.
  - If both are asserted, write both.
  - Ignored in other states; the pipeline is stalled, so they cannot be architecturally present.
- MFHI/MFLO read hi_o/lo_o directly. Any MFHI/MFLO behind a MULT is stalled behind it by stallreq_o.
- Precedence in IDLE: if ex_mul_valid_i and ex_mthi_i/ex_mtlo_i are both asserted, the multiply wins and MT* is ignored (decode never produces both).
- Reset mid-operation: asynchronous return to IDLE with reset values. Any in-flight product is discarded. The multiplier is reset by the same rst.
- Width rule: HI = product[2*DW-1:DW], LO = product[DW-1:0]. No sign handling here; sign correction is done by the multiplier.

Optional Feature:
- Macro: HILO_MADD_EN.
- When defined:
  - Adds port ex_acc_op_i in 2: 00=none, 01=MADD/MADDU, 10=MSUB/MSUBU.
  - The op is latched at issue.
  - On BUSY capture, {hi_o,lo_o}<={hi_o,lo_o}+mul_result_i for 01, or {hi_o,lo_o}-mul_result_i for 10. Arithmetic is modulo 2^(2*DW).
  - Code 11 is treated as 00.
- When undefined: the port is absent and capture is a plain overwrite.

Test Plan:
- Reset, then idle until mul_ready_i=1 -> hi_o=lo_o=0, stallreq_o=0, mul_start_o=1.
- MULTU rs=0xFFFFFFFF rt=0x2 -> stallreq_o high exactly 38 cycles; then hi_o=0x00000001, lo_o=0xFFFFFFFE; mul_a_o/mul_b_o stable throughout.
- MULT rs=0xFFFFFFFD(-3) rt=0x7 -> hi_o=0xFFFFFFFF, lo_o=0xFFFFFFEB; mul_signed_o=1 during op.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back in IDLE -> both written on consecutive edges with no stall; then MULT asserted with MTLO in the same cycle -> MTLO ignored, product written.
- ex_mul_valid_i asserted on the first cycle after reset (mul_ready_i=0) -> stays in IDLE with stallreq_o=1 until mul_ready_i=1, then completes the correct product; rst pulsed mid-BUSY -> immediate IDLE, hi_o=lo_o=0.
- HILO_MADD_EN: HI/LO=0x00000000_00000010, MADD 3*4 -> 0x1C; then MSUB 0x20*1 -> 0xFFFFFFFF_FFFFFFFC.

Source files
------------

// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: EX-stage controller between the pipeline and a 32-iteration
//   sequential multiplier; owns the architectural HI/LO registers.
// Latency: 38 stalled cycles from issue to release (no early-out); MTHI/MTLO
//   update HI/LO at the next edge with no stall.
// Backpressure: stallreq_o holds EX while a multiply is pending or in flight.
//
// Optional feature macro: HILO_MADD_EN (adds ex_acc_op_i for MADD/MSUB).
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   ex_mul_valid_i     MULT/MULTU in EX; ex_mul_signed_i selects MULT
//   ex_rs_i, ex_rt_i   multiply operands
//   ex_mthi_i/ex_mtlo_i/ex_wdata_i   MTHI/MTLO write request and data
//   ex_acc_op_i        (HILO_MADD_EN only) 00 none, 01 add, 10 subtract
//   mul_start_o        multiplier start/hold (1 = run/hold result, 0 = stop)
//   mul_signed_o, mul_a_o, mul_b_o   registered operands to the multiplier
//   mul_result_i, mul_ready_i        product {hi,lo} and result-valid
//   hi_o, lo_o         architectural HI/LO
//   stallreq_o         combinational pipeline stall request
module hilo_mul_ctrl #(
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_mul_valid_i,
  input  logic            ex_mul_signed_i,
  input  logic [DW-1:0]   ex_rs_i,
  input  logic [DW-1:0]   ex_rt_i,
  input  logic            ex_mthi_i,
  input  logic            ex_mtlo_i,
  input  logic [DW-1:0]   ex_wdata_i,
`ifdef HILO_MADD_EN
  input  logic [1:0]      ex_acc_op_i,
`endif
  output logic            mul_start_o,
  output logic            mul_signed_o,
  output logic [DW-1:0]   mul_a_o,
  output logic [DW-1:0]   mul_b_o,
  input  logic [2*DW-1:0] mul_result_i,
  input  logic            mul_ready_i,
  output logic [DW-1:0]   hi_o,
  output logic [DW-1:0]   lo_o,
  output logic            stallreq_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KICK = 2'd1,
    ARM  = 2'd2,
    BUSY = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            start_q, start_d;
  logic            signed_q, signed_d;
  logic [DW-1:0]   a_q, a_d;
  logic [DW-1:0]   b_q, b_d;
  logic [DW-1:0]   hi_q, hi_d;
  logic [DW-1:0]   lo_q, lo_d;
  logic            stall;
  logic [2*DW-1:0] wb_val;

`ifdef HILO_MADD_EN
  logic [1:0]      acc_op_q, acc_op_d;

  // Accumulate ops combine the product with the current HI/LO pair; code 11
  // falls through to a plain overwrite.
  always_comb begin
    wb_val = mul_result_i;
    case (acc_op_q)
      2'b01:   wb_val = {hi_q, lo_q} + mul_result_i;
      2'b10:   wb_val = {hi_q, lo_q} - mul_result_i;
      default: wb_val = mul_result_i;
    endcase
  end
`else
  always_comb begin
    wb_val = mul_result_i;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      start_q  <= 1'b1;
      signed_q <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef HILO_MADD_EN
      acc_op_q <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      start_q  <= start_d;
      signed_q <= signed_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
`ifdef HILO_MADD_EN
      acc_op_q <= acc_op_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    signed_d = signed_q;
    a_d      = a_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    stall    = 1'b0;
`ifdef HILO_MADD_EN
    acc_op_d = acc_op_q;
`endif
    case (state_q)
      IDLE: begin
        start_d = 1'b1;
        if (ex_mul_valid_i) begin
          stall = 1'b1;
          // Only issue once the multiplier is parked in result-hold; right
          // after reset it is still running its power-on cycle.
          if (mul_ready_i) begin
            a_d      = ex_rs_i;
            b_d      = ex_rt_i;
            signed_d = ex_mul_signed_i;
            start_d  = 1'b0;
`ifdef HILO_MADD_EN
            acc_op_d = ex_acc_op_i;
`endif
            state_d  = KICK;
          end
        end else begin
          if (ex_mthi_i) hi_d = ex_wdata_i;
          if (ex_mtlo_i) lo_d = ex_wdata_i;
        end
      end
      KICK: begin
        stall   = 1'b1;
        start_d = 1'b1;
        state_d = ARM;
      end
      ARM: begin
        // Ready can still read high from the previous hold; only a low
        // proves the new operation has actually begun.
        stall = 1'b1;
        if (!mul_ready_i) state_d = BUSY;
      end
      BUSY: begin
        if (mul_ready_i) begin
          hi_d    = wb_val[2*DW-1:DW];
          lo_d    = wb_val[DW-1:0];
          state_d = IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign mul_start_o  = start_q;
  assign mul_signed_o = signed_q;
  assign mul_a_o      = a_q;
  assign mul_b_o      = b_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign stallreq_o   = stall;

endmodule
